// File: rtl/vend_ctrl_param.sv
// Parametrised Moore vending controller: nickel-unit credit, exact change, wrapping sales count.
// Optional cancel/refund path is built only when VEND_CANCEL_EN is defined.
module vend_ctrl_param #(
  parameter int PRICE    = 5,
  parameter int CREDIT_W = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk_i,
  input  logic                reset_n,
  input  logic                nickle_i,
  input  logic                dime_i,
  input  logic                quarter_i,
  input  logic                cancel_i,
  output logic                soda_o,
  output logic [CREDIT_W-1:0] change_o,
  output logic                refund_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic [CNT_W-1:0]    sales_o
);

`ifdef VEND_CANCEL_EN
  typedef enum logic [1:0] {COLLECT, VEND, REFUND} state_t;
`else
  typedef enum logic {COLLECT, VEND} state_t;
`endif

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   PRICE_L = {1'b0, PRICE_C};

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic [CNT_W-1:0]    sales_q, sales_d;
  logic [CREDIT_W:0]   coin_v, base, sum;

`ifndef VEND_CANCEL_EN
  logic unused_cancel;
  assign unused_cancel = cancel_i;
`endif

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= COLLECT;
      credit_q <= '0;
      change_q <= '0;
      sales_q  <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      sales_q  <= sales_d;
    end
  end

  // VEND/REFUND restart collection from zero so a coin in those cycles is not lost
  always_comb begin
    coin_v   = '0;
    if (nickle_i)       coin_v = (CREDIT_W+1)'(1);
    else if (dime_i)    coin_v = (CREDIT_W+1)'(2);
    else if (quarter_i) coin_v = (CREDIT_W+1)'(5);
    base     = (state_q == COLLECT) ? {1'b0, credit_q} : '0;
    sum      = base + coin_v;
    state_d  = COLLECT;
    credit_d = sum[CREDIT_W-1:0];
    change_d = '0;
    sales_d  = sales_q;
`ifdef VEND_CANCEL_EN
    if (cancel_i && (sum != '0)) begin
      state_d  = REFUND;
      credit_d = '0;
      change_d = sum[CREDIT_W-1:0];
    end else
`endif
    if (sum >= PRICE_L) begin
      state_d  = VEND;
      credit_d = '0;
      change_d = sum[CREDIT_W-1:0] - PRICE_C;
      sales_d  = sales_q + CNT_W'(1);
    end
  end

  assign soda_o   = (state_q == VEND);
`ifdef VEND_CANCEL_EN
  assign refund_o = (state_q == REFUND);
`else
  assign refund_o = 1'b0;
`endif
  assign change_o = change_q;
  assign credit_o = credit_q;
  assign sales_o  = sales_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Self-checking bench for vend_ctrl_param: integer credit/sales model compared every cycle,
// plus hand-computed directed expectations. Honours VEND_CANCEL_EN like the design.
module tb_vend_ctrl_param;
  localparam int PRICE    = 5;
  localparam int CREDIT_W = 4;
  localparam int CNT_W    = 8;
`ifdef VEND_CANCEL_EN
  localparam bit CAN_EN = 1'b1;
`else
  localparam bit CAN_EN = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic reset_n = 1'b0;
  logic nickle_i = 1'b0, dime_i = 1'b0, quarter_i = 1'b0, cancel_i = 1'b0;
  logic                soda_o, refund_o;
  logic [CREDIT_W-1:0] change_o, credit_o;
  logic [CNT_W-1:0]    sales_o;

  int tests_run = 0;
  int tests_failed = 0;
  bit chk_en = 1'b0;

  int m_credit = 0, m_sales = 0, e_change = 0;
  bit e_soda = 1'b0, e_ref = 1'b0;

  vend_ctrl_param #(.PRICE(PRICE), .CREDIT_W(CREDIT_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .reset_n(reset_n), .nickle_i(nickle_i), .dime_i(dime_i),
    .quarter_i(quarter_i), .cancel_i(cancel_i), .soda_o(soda_o), .change_o(change_o),
    .refund_o(refund_o), .credit_o(credit_o), .sales_o(sales_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_sales = 0; e_change = 0; e_soda = 1'b0; e_ref = 1'b0;
  endtask

  // Credit after a vend/refund is zero, so one running credit value covers every state
  task automatic model_step(input bit n, input bit d, input bit q, input bit c);
    int v, sum;
    v = n ? 1 : d ? 2 : q ? 5 : 0;
    sum = m_credit + v;
    e_soda = 1'b0; e_ref = 1'b0; e_change = 0;
    if (CAN_EN && c && sum > 0) begin
      e_ref = 1'b1; e_change = sum; m_credit = 0;
    end else if (sum >= PRICE) begin
      e_soda = 1'b1; e_change = sum - PRICE; m_credit = 0;
      m_sales = (m_sales + 1) % (1 << CNT_W);
    end else begin
      m_credit = sum;
    end
  endtask

  task automatic cycle(input bit n, input bit d, input bit q, input bit c);
    @(negedge clk_i);
    nickle_i = n; dime_i = d; quarter_i = q; cancel_i = c;
    @(posedge clk_i);
    #1;
    model_step(n, d, q, c);
    nickle_i = 1'b0; dime_i = 1'b0; quarter_i = 1'b0; cancel_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("model_soda",   int'(soda_o),   int'(e_soda));
      chk("model_refund", int'(refund_o), int'(e_ref));
      chk("model_change", int'(change_o), e_change);
      chk("model_credit", int'(credit_o), m_credit);
      chk("model_sales",  int'(sales_o),  m_sales);
      if (soda_o && refund_o) chk("soda_refund_excl", 1, 0);
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_soda",   int'(soda_o),   0);
    chk("rst_refund", int'(refund_o), 0);
    chk("rst_change", int'(change_o), 0);
    chk("rst_credit", int'(credit_o), 0);
    chk("rst_sales",  int'(sales_o),  0);
    @(negedge clk_i);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // single quarter vends at default price
    cycle(0, 0, 1, 0);
    chk("q_soda", int'(soda_o), 1);
    chk("q_change", int'(change_o), 0);
    chk("q_sales", int'(sales_o), 1);
    cycle(0, 0, 0, 0);
    chk("q_soda_off", int'(soda_o), 0);

    // dime, dime, dime
    cycle(0, 1, 0, 0); chk("ddd_c2", int'(credit_o), 2);
    cycle(0, 1, 0, 0); chk("ddd_c4", int'(credit_o), 4);
    cycle(0, 1, 0, 0);
    chk("ddd_soda", int'(soda_o), 1);
    chk("ddd_change", int'(change_o), 1);

    // dime, nickel, quarter -> change 3; dime during VEND keeps the coin
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0); chk("dn_c3", int'(credit_o), 3);
    cycle(0, 0, 1, 0); chk("dnq_change", int'(change_o), 3);
    cycle(0, 1, 0, 0); chk("vend_dime_c2", int'(credit_o), 2);
    cycle(0, 1, 0, 0); chk("dd_c4", int'(credit_o), 4);
    cycle(0, 0, 1, 0);
    chk("c4q_change", int'(change_o), 4);
    chk("c4q_sales", int'(sales_o), 4);

    // nickel has priority over quarter
    cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 0);
    chk("prio_credit", int'(credit_o), 1);
    chk("prio_soda", int'(soda_o), 0);

    // nickel during a vend cycle
    cycle(0, 0, 1, 0); chk("c1q_change", int'(change_o), 1);
    cycle(1, 0, 0, 0); chk("vend_nickel_c1", int'(credit_o), 1);

    // cancel behaviour
    cycle(0, 1, 0, 0); chk("cancel_pre_c3", int'(credit_o), 3);
    cycle(0, 0, 0, 1);
    if (CAN_EN) begin
      chk("cancel_refund", int'(refund_o), 1);
      chk("cancel_change", int'(change_o), 3);
      chk("cancel_credit", int'(credit_o), 0);
    end else begin
      chk("nocancel_refund", int'(refund_o), 0);
      chk("nocancel_credit", int'(credit_o), 3);
    end
    cycle(0, 0, 1, 0);  // clears credit in either build
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0); chk("cd_pre_c4", int'(credit_o), 4);
    cycle(0, 1, 0, 1);
    if (CAN_EN) begin
      chk("cd_refund", int'(refund_o), 1);
      chk("cd_change", int'(change_o), 6);
      chk("cd_soda", int'(soda_o), 0);
    end else begin
      chk("cd_soda_nocancel", int'(soda_o), 1);
      chk("cd_change_nocancel", int'(change_o), 1);
    end

    // async reset at credit 3
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0); chk("rr_pre_c3", int'(credit_o), 3);
    @(negedge clk_i);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_soda",   int'(soda_o),   0);
    chk("arst_refund", int'(refund_o), 0);
    chk("arst_change", int'(change_o), 0);
    chk("arst_credit", int'(credit_o), 0);
    chk("arst_sales",  int'(sales_o),  0);
    @(negedge clk_i);
    #1;
    reset_n = 1'b1;
    cycle(0, 0, 1, 0);
    chk("post_rst_soda", int'(soda_o), 1);
    chk("post_rst_change", int'(change_o), 0);
    chk("post_rst_sales", int'(sales_o), 1);

    // 255 more back-to-back vends wrap the counter
    for (int i = 0; i < 255; i++) cycle(0, 0, 1, 0);
    chk("wrap_sales", int'(sales_o), 0);
    chk("wrap_soda", int'(soda_o), 1);
    cycle(0, 0, 0, 0);
    chk("wrap_idle_soda", int'(soda_o), 0);

    @(negedge clk_i);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
